// File: rtl/adc_pkg.sv
// adc_pkg: constants and types shared by the ADC slicer and the frame
// serializer, plus the serializer read-side state encoding.
package adc_pkg;

    localparam int ADC_SAMPLE_W          = 18;
    localparam int ADC_SAMPLES_PER_FRAME = 12;
    localparam int ADC_FRAME_W           = ADC_SAMPLE_W * ADC_SAMPLES_PER_FRAME;
    localparam int ADC_CHANNELS          = 4;

    typedef logic [ADC_SAMPLE_W-1:0] adc_sample_t;
    typedef logic [ADC_FRAME_W-1:0]  adc_frame_t;

    // Read side is either waiting for a frame or streaming the head frame.
    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_frame_serializer_if.sv
// adc_frame_serializer_if: AXI-Stream style sample output of the serializer.
interface adc_frame_serializer_if
    import adc_pkg::*;
#(
    parameter int SAMPLE_W = ADC_SAMPLE_W
) ();

    logic [SAMPLE_W-1:0] m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;
    logic                m_tuser;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        output m_tuser,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        input  m_tuser,
        output m_tready
    );

endinterface

// File: rtl/adc_frame_buf2.sv
// adc_frame_buf2: two-entry ping-pong frame store. Push and pop may occur in
// the same cycle, including when full (the caller only pushes while full if it
// also pops, so the slot being overwritten is the one leaving).
module adc_frame_buf2
    import adc_pkg::*;
#(
    parameter int FRAME_W = ADC_FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [FRAME_W-1:0] push_data,
    input  logic               pop,
    output logic [FRAME_W-1:0] head,
    output logic [1:0]         level,
    output logic               full,
    output logic               empty
);

    logic [FRAME_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         level_q;

    // Frame storage is data only; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset empties the store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            level_q <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level_q <= level_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign level = level_q;
    assign full  = (level_q == 2'd2);
    assign empty = (level_q == 2'd0);

endmodule

// File: rtl/adc_frame_serializer.sv
// adc_frame_serializer: buffers up to two ADC frames and streams them one
// sample per handshake, oldest first, with tuser/tlast packet framing.
// Optional build macro ADC_SER_DROP_CNT_EN adds a saturating dropped-frame
// counter on drop_count; without it drop_count is tied to zero.
module adc_frame_serializer
    import adc_pkg::*;
#(
    parameter int SAMPLE_W       = ADC_SAMPLE_W,
    parameter int SAMPLES        = ADC_SAMPLES_PER_FRAME,
    parameter int FRAMES_PER_PKT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SAMPLE_W*SAMPLES-1:0]  data_in,
    input  logic                         data_in_valid,
    adc_frame_serializer_if.master       axis,
    output logic [1:0]                   buf_level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [15:0]                  drop_count
);

    localparam int FRAME_W = SAMPLE_W * SAMPLES;
    localparam int IDX_W   = cnt_width(SAMPLES);
    localparam int FC_W    = cnt_width(FRAMES_PER_PKT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_PKT - 1);

    ser_state_t          state_q;
    ser_state_t          state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [FC_W-1:0]     fc_q;
    logic [FRAME_W-1:0]  head;
    logic [SAMPLE_W-1:0] head_sample;
    logic                buf_full;
    logic                buf_empty;
    logic                handshake;
    logic                pop;
    logic                push;
    logic                drop;

    assign handshake = axis.m_tvalid & axis.m_tready;
    assign pop       = handshake && (idx_q == IDX_LAST);
    assign push      = data_in_valid && (!buf_full || pop);
    assign drop      = data_in_valid && buf_full && !pop;

    adc_frame_buf2 #(
        .FRAME_W (FRAME_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .head      (head),
        .level     (buf_level),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Select the current sample of the head frame from registered storage.
    always_comb begin
        head_sample = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                head_sample = head[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Read-side state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows buffer occupancy; outputs are zero unless streaming.
    always_comb begin
        state_d       = state_q;
        axis.m_tvalid = 1'b0;
        axis.m_tdata  = '0;
        axis.m_tuser  = 1'b0;
        axis.m_tlast  = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (push) begin
                    state_d = SER_STREAM;
                end
            end
            SER_STREAM: begin
                axis.m_tvalid = !buf_empty;
                axis.m_tdata  = head_sample;
                axis.m_tuser  = (fc_q == '0) && (idx_q == '0);
                axis.m_tlast  = (fc_q == FC_LAST) && (idx_q == IDX_LAST);
                if (pop && !push && (buf_level == 2'd1)) begin
                    state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Sample index advances per handshake; frame counter advances per pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            fc_q  <= '0;
        end else begin
            if (handshake) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            if (pop) begin
                fc_q <= (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef ADC_SER_DROP_CNT_EN
    // Saturating dropped-frame counter; a drop coinciding with a clear counts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 16'd0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_count <= 16'd0;
        end
    end
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_adc_frame_serializer.sv
// tb_adc_frame_serializer: directed and random frames against a queue-based
// reference; a negedge monitor compares every presented sample in order.
module tb_adc_frame_serializer;
    import adc_pkg::*;

    localparam int SW  = 18;
    localparam int NS  = 12;
    localparam int FPP = 2;
    localparam int FW  = SW * NS;

    typedef struct {
        logic [SW-1:0] data;
        logic          user;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [1:0]    buf_level;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic [15:0]   drop_count;

    adc_frame_serializer_if #(.SAMPLE_W(SW)) axis ();

    adc_frame_serializer #(
        .SAMPLE_W       (SW),
        .SAMPLES        (NS),
        .FRAMES_PER_PKT (FPP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .axis          (axis),
        .buf_level     (buf_level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    // Reference state: frames held, position in head frame, frames accepted since reset.
    exp_t sb[$];
    int   m_level = 0;
    int   m_idx = 0;
    int   m_accepted = 0;
    int   m_ovf = 0;
    int   m_drops = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the reference is advanced by the rules for that cycle.
    task automatic applyStimulus(input logic dv, input logic [FW-1:0] f, input logic rdy, input logic clr);
        bit hs, pop, acc, drop;
        exp_t e;
        data_in_valid = dv;
        data_in       = f;
        axis.m_tready = rdy;
        ovf_clr       = clr;
        hs   = (m_level > 0) && rdy;
        pop  = hs && (m_idx == NS - 1);
        acc  = dv && ((m_level < 2) || pop);
        drop = dv && !acc;
        @(posedge clk);
        if (hs) m_idx = pop ? 0 : m_idx + 1;
        m_level = m_level + int'(acc) - int'(pop);
        if (acc) begin
            for (int k = 0; k < NS; k++) begin
                e.data = f[k*SW +: SW];
                e.user = ((m_accepted % FPP) == 0) && (k == 0);
                e.last = ((m_accepted % FPP) == FPP - 1) && (k == NS - 1);
                sb.push_back(e);
            end
            m_accepted++;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
`ifdef ADC_SER_DROP_CNT_EN
        if (drop) m_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : m_drops);
        else if (clr) m_drops = 0;
`endif
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b0);
    endtask

    function automatic logic [FW-1:0] randFrame();
        logic [FW-1:0] f;
        for (int k = 0; k < NS; k++) f[k*SW +: SW] = SW'($urandom);
        return f;
    endfunction

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_tvalid"}, 32'(axis.m_tvalid), 0);
        checkOutput({tag, "_tdata"},  32'(axis.m_tdata), 0);
        checkOutput({tag, "_tuser"},  32'(axis.m_tuser), 0);
        checkOutput({tag, "_tlast"},  32'(axis.m_tlast), 0);
        checkOutput({tag, "_level"},  32'(buf_level), 0);
        checkOutput({tag, "_ovf"},    32'(overflow), 0);
        checkOutput({tag, "_drops"},  32'(drop_count), 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic doReset();
        data_in_valid = 1'b0;
        ovf_clr       = 1'b0;
        rst_n         = 1'b0;
        #1;
        checkZeros("async_rst");
        sb.delete();
        m_level = 0; m_idx = 0; m_accepted = 0; m_ovf = 0; m_drops = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares presented samples in order and status against the reference.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checkOutput("rst_tvalid", 32'(axis.m_tvalid), 0);
            checkOutput("rst_tdata", 32'(axis.m_tdata), 0);
        end else begin
            checkOutput("tvalid", 32'(axis.m_tvalid), 32'(sb.size() > 0));
            checkOutput("buf_level", 32'(buf_level), 32'(m_level));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("drop_count", 32'(drop_count), 32'(m_drops));
            if (axis.m_tvalid && sb.size() > 0) begin
                e = sb[0];
                checkOutput("tdata", 32'(axis.m_tdata), 32'(e.data));
                checkOutput("tuser", 32'(axis.m_tuser), 32'(e.user));
                checkOutput("tlast", 32'(axis.m_tlast), 32'(e.last));
                if (axis.m_tready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [FW-1:0] f;
        int cnt;
        axis.m_tready = 1'b0;
        @(posedge clk);
        #1;
        checkZeros("reset");
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Single frame of 0x100+k with the sink always ready.
        for (int k = 0; k < NS; k++) f[k*SW +: SW] = SW'(32'h100 + k);
        applyStimulus(1'b1, f, 1'b1, 1'b0);
        checkOutput("single_latency", 32'(axis.m_tvalid), 1);
        checkOutput("single_first", 32'(axis.m_tdata), 32'h100);
        idle(14, 1'b1);

        // Two frames twelve cycles apart from a fresh packet: no bubble, tlast on B only.
        doReset();
        applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
        idle(11, 1'b1);
        applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
        idle(14, 1'b1);

        // Backpressure held at sample 3 for five cycles.
        applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(5, 1'b0);
        idle(14, 1'b1);

        // Three strobes into a stalled sink: the third is dropped.
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        checkOutput("ovf_full_level", 32'(buf_level), 2);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        idle(3, 1'b0);
        idle(30, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Strobe exactly on the last-sample handshake while full.
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40 && cnt == 0; i++) begin
            if (m_level == 2 && m_idx == NS - 1) begin
                applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
                cnt = 1;
            end else begin
                applyStimulus(1'b0, '0, 1'b1, 1'b0);
            end
        end
        checkOutput("fullpop_level", 32'(buf_level), 2);
        checkOutput("fullpop_no_ovf", 32'(overflow), 0);

        // Clear coinciding with a drop after an earlier drop.
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b0);
        applyStimulus(1'b1, randFrame(), 1'b0, 1'b1);
        idle(40, 1'b1);

        // Reset at sample 6 of a frame; next frame must open a packet.
        applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
        idle(6, 1'b1);
        doReset();
        applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
        checkOutput("post_rst_tuser", 32'(axis.m_tuser), 1);
        idle(14, 1'b1);

        // Random traffic: dense then sparse strobes, random ready and clears.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 9) < 2), randFrame(),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), randFrame(),
                          ($urandom_range(0, 1) == 0), 1'b0);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 300 && (sb.size() > 0 || m_level > 0); i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain_timeout: %0d samples outstanding, expected 0", sb.size());
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
